// File: rtl/wb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : wb_uart_rx
// Description : Wishbone-slave UART receiver. Oversamples the 8N1 serial
//               input with a programmable bit period of DIVIDER+2 cycles,
//               buffers received bytes in a small FIFO and exposes
//               DIVIDER / RXDATA / STATUS / ID through a 4-register window.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_uart_rx #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     uart_rx_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     irq_o
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [31:0] ID_VALUE = 32'h5EC0_DE01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic        rx_meta, rxs, rxs_d;
    state_t      state, state_n;
    logic [32:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [31:0] div_l, div_l_n;
    logic [32:0] period, half;
    logic        push_n, ferr_set;
    logic        push_req;
    logic [7:0]  push_data;

    logic [31:0] divider;
    logic        overrun, frame_err;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic        fifo_empty, fifo_full, do_push, pop, overrun_set;

    logic        ack_r;
    logic [WB_DATA_WIDTH-1:0] data_r;
    logic        access, take, wr, rd;
    logic [1:0]  reg_sel;
    logic [31:0] rdata, status, count_ext;
    logic        unused_ok;

    // Bits of the bus that carry no meaning for a full-word register window
    assign unused_ok = ^{wb_sel_i, wb_addr_i, wb_data_i};

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Bit period and half period in 33 bits so DIVIDER=all-ones cannot wrap
    assign period = {1'b0, div_l} + 33'd2;
    assign half   = period >> 1;

    // Receiver state and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            div_l     <= 32'd1;
            push_req  <= 1'b0;
            push_data <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            div_l     <= div_l_n;
            push_req  <= push_n;
            push_data <= shreg;
        end
    end

    // Receiver next-state: mid-bit sampling driven by the cycle counter
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        div_l_n   = div_l;
        push_n    = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rxs_d && !rxs) begin
                    div_l_n = divider;
                    cnt_n   = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == half - 33'd1) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + 33'd1;
                end
            end
            ST_DATA: begin
                if (cnt == period - 33'd1) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 33'd1;
                end
            end
            ST_STOP: begin
                if (cnt == period - 33'd1) begin
                    cnt_n    = '0;
                    state_n  = ST_IDLE;
                    push_n   = rxs;
                    ferr_set = !rxs;
                end else begin
                    cnt_n = cnt + 33'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus decode: side effects only on the edge that raises ack
    // ------------------------------------------------------------------
    assign access  = wb_cyc_i & wb_stb_i;
    assign take    = access & ~ack_r;
    assign wr      = take & wb_we_i;
    assign rd      = take & ~wb_we_i;
    assign reg_sel = wb_addr_i[3:2];

    // ------------------------------------------------------------------
    // FIFO: a pop frees a slot for a same-cycle push when full
    // ------------------------------------------------------------------
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CW'(FIFO_DEPTH));
    assign pop         = rd && (reg_sel == 2'd1) && !fifo_empty;
    assign do_push     = push_req && (!fifo_full || pop);
    assign overrun_set = push_req && fifo_full && !pop;

    // FIFO storage, no reset needed since count gates every read
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
        end
    end

    // Divider register and sticky error flags (set beats clear)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            divider   <= 32'd1;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr && reg_sel == 2'd0) divider <= wb_data_i[31:0];
            if (overrun_set)                                  overrun <= 1'b1;
            else if (wr && reg_sel == 2'd2 && wb_data_i[2])   overrun <= 1'b0;
            if (ferr_set)                                     frame_err <= 1'b1;
            else if (wr && reg_sel == 2'd2 && wb_data_i[3])   frame_err <= 1'b0;
        end
    end

    assign count_ext = 32'(count);
    assign status    = {24'd0, count_ext[3:0], frame_err, overrun, fifo_full, !fifo_empty};

    // Read multiplexer
    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = divider;
            2'd1: rdata = fifo_empty ? 32'd0 : {23'd0, 1'b1, mem[rptr]};
            2'd2: rdata = status;
            2'd3: rdata = ID_VALUE;
            default: rdata = '0;
        endcase
    end

    // Single-cycle ack with registered read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_r  <= 1'b0;
            data_r <= '0;
        end else begin
            ack_r  <= take;
            data_r <= rd ? WB_DATA_WIDTH'(rdata) : '0;
        end
    end

    assign wb_ack_o  = ack_r & wb_cyc_i;
    assign wb_data_o = wb_ack_o ? data_r : '0;
    assign irq_o     = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_uart_rx
// Description : Self-checking bench for wb_uart_rx. A queue-based model of
//               the receive FIFO and sticky flags predicts every register
//               read; serial frames are driven at the programmed bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_uart_rx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the software-visible state
    logic [7:0]  exp_q[$];
    bit          m_ovr = 1'b0;
    bit          m_ferr = 1'b0;
    int unsigned m_div = 1;

    wb_uart_rx #(
        .WB_DATA_WIDTH(32),
        .WB_ADDR_WIDTH(32),
        .WB_SEL_WIDTH (4),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .uart_rx_i(uart_rx),
        .wb_addr_i(addr),
        .wb_data_i(dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_ack_o (ack),
        .wb_data_o(dat_o),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (exp_q.size() != 0);
        s[1]   = (exp_q.size() == DEPTH);
        s[2]   = m_ovr;
        s[3]   = m_ferr;
        s[7:4] = 4'(exp_q.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_pop();
        if (exp_q.size() == 0) return 32'd0;
        return {23'd0, 1'b1, exp_q.pop_front()};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_div  = 1;
    endfunction

    // One Wishbone access; a missing ack is itself a failed comparison
    task automatic wb_access(input logic wr, input logic [1:0] reg_idx,
                             input logic [31:0] wdata, output logic [31:0] rdata);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = wr;
        addr = {28'd0, reg_idx, 2'b00}; dat_i = wdata;
        rdata = 32'hDEAD_BEEF;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        checks++;
        if (!ack) begin
            errors++;
            $display("FAIL ack_timeout reg=%0d got ack=%b want 1", reg_idx, ack);
        end else begin
            rdata = dat_o;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] reg_idx, input logic [31:0] wdata);
        logic [31:0] dummy;
        wb_access(1'b1, reg_idx, wdata, dummy);
    endtask

    // Serial frame at the model's current bit period; updates the model
    task automatic send_frame(input logic [7:0] b, input bit stop, input int gap);
        int p;
        p = int'(m_div) + 2;
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (p) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (p) @(posedge clk);
            #1;
        end
        uart_rx = stop;
        repeat (p) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        if (stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        repeat (gap) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int acks;
        do_reset();
        #1;
        checks++;
        if (irq !== 1'b0 || ack !== 1'b0 || dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got irq=%b ack=%b data=%h want 0 0 0", irq, ack, dat_o);
        end
        wb_access(1'b0, 2'd0, 32'd0, r);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL reset_divider got %h want 00000001", r); end
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_status got %h want 00000000", r); end
        wb_access(1'b0, 2'd3, 32'd0, r);
        checks++;
        if (r !== 32'h5EC0_DE01) begin errors++; $display("FAIL id got %h want 5ec0de01", r); end
        wb_access(1'b0, 2'd1, 32'd0, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_rxdata got %h want 00000000", r); end
        // Strobe held for four edges: ack must toggle, never stay high
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'hC;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
            checks++;
            if (!ack && dat_o !== 32'd0) begin
                errors++;
                $display("FAIL data_when_no_ack got %h want 00000000", dat_o);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (acks != 2) begin errors++; $display("FAIL ack_pulse got %0d acks want 2", acks); end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        wb_write(2'd0, 32'd8);
        m_div = 8;
        wb_access(1'b0, 2'd0, 32'd0, r);
        checks++;
        if (r !== 32'd8) begin errors++; $display("FAIL divider_rb got %h want 00000008", r); end
        send_frame(8'hA5, 1'b1, 4);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got %b want 1", irq); end
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== exp_status()) begin errors++; $display("FAIL basic_status got %h want %h", r, exp_status()); end
        wb_access(1'b0, 2'd1, 32'd0, r);
        checks++;
        if (r !== exp_pop()) begin errors++; $display("FAIL basic_rxdata got %h want 000001a5", r); end
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== exp_status() || irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained got status=%h irq=%b want %h 0", r, irq, exp_status());
        end
    endtask

    task automatic test_glitch();
        logic [31:0] r;
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL glitch_status got %h want 00000000", r); end
        send_frame(8'h3C, 1'b1, 4);
        wb_access(1'b0, 2'd1, 32'd0, r);
        checks++;
        if (r !== exp_pop()) begin errors++; $display("FAIL glitch_next_frame got %h want 0000013c", r); end
    endtask

    task automatic test_frame_err();
        logic [31:0] r;
        send_frame(8'h55, 1'b0, 4);
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== exp_status() || irq !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_status got %h irq=%b want %h 0", r, irq, exp_status());
        end
        wb_write(2'd2, 32'h08);
        m_ferr = 1'b0;
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== exp_status()) begin errors++; $display("FAIL frame_err_clear got %h want %h", r, exp_status()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, (i == 5) ? 4 : 0);
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== exp_status()) begin errors++; $display("FAIL overrun_status got %h want %h", r, exp_status()); end
        for (int i = 0; i < 5; i++) begin
            logic [31:0] e;
            e = exp_pop();
            wb_access(1'b0, 2'd1, 32'd0, r);
            checks++;
            if (r !== e) begin errors++; $display("FAIL b2b_rxdata[%0d] got %h want %h", i, r, e); end
        end
        wb_write(2'd2, 32'h04);
        m_ovr = 1'b0;
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== exp_status()) begin errors++; $display("FAIL overrun_clear got %h want %h", r, exp_status()); end
    endtask

    task automatic test_random();
        logic [31:0] r, e, v;
        v = $urandom;
        wb_write(2'd0, v);
        wb_access(1'b0, 2'd0, 32'd0, r);
        checks++;
        if (r !== v) begin errors++; $display("FAIL rand_divider_rb got %h want %h", r, v); end
        for (int it = 0; it < 10; it++) begin
            m_div = $urandom_range(14, 3);
            wb_write(2'd0, m_div);
            send_frame(8'($urandom), ($urandom_range(5, 0) != 0), 4);
            wb_access(1'b0, 2'd2, 32'd0, r);
            checks++;
            if (r !== exp_status()) begin errors++; $display("FAIL rand_status[%0d] got %h want %h", it, r, exp_status()); end
            repeat ($urandom_range(2, 0)) begin
                e = exp_pop();
                wb_access(1'b0, 2'd1, 32'd0, r);
                checks++;
                if (r !== e) begin errors++; $display("FAIL rand_rxdata[%0d] got %h want %h", it, r, e); end
            end
            if ($urandom_range(1, 0) == 1) begin
                wb_write(2'd2, 32'h0C);
                m_ovr = 1'b0;
                m_ferr = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int p;
        wb_write(2'd0, 32'd8);
        m_div = 8;
        send_frame(8'h77, 1'b1, 4);
        p = 10;
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (p) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (3 * p + p / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq got %b want 0", irq); end
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        wb_access(1'b0, 2'd0, 32'd0, r);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL midreset_divider got %h want 00000001", r); end
        wb_access(1'b0, 2'd2, 32'd0, r);
        checks++;
        if (r !== exp_status()) begin errors++; $display("FAIL midreset_status got %h want %h", r, exp_status()); end
        wb_write(2'd0, 32'd8);
        m_div = 8;
        send_frame(8'h81, 1'b1, 4);
        wb_access(1'b0, 2'd1, 32'd0, r);
        checks++;
        if (r !== exp_pop()) begin errors++; $display("FAIL midreset_next_frame got %h want 00000181", r); end
        wb_access(1'b0, 2'd1, 32'd0, r);
        checks++;
        if (r !== exp_pop()) begin errors++; $display("FAIL midreset_empty got %h want 00000000", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
